mem_interconnect: RTL and testbench



---
 rtl/mem_interconnect_pkg.sv | 25 ++
 rtl/mem_addr_decode.sv | 36 +++
 rtl/mem_interconnect.sv | 184 ++++++++++++++++++
 tb/tb_mem_interconnect.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_interconnect_pkg.sv
// Shared types and constants for the PicoRV32 memory-bus interconnect.
// Timeout support is selected with MEM_INTERCONNECT_TIMEOUT_EN.
package mem_interconnect_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        CAUSE_DECODE  = 1'b0,
        CAUSE_TIMEOUT = 1'b1
    } cause_t;

    localparam logic [31:0] DEFAULT_ERR_DATA = 32'hBADB_AD00;

    // Wide enough for the largest legal TIMEOUT (65535).
    localparam int CNT_W = 16;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_addr_decode.sv
// Base/mask window decoder; the lowest matching slave index wins.
// Purely combinational, no clock or reset.
module mem_addr_decode
    import mem_interconnect_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_W     = 32,
    parameter int SEL_W      = 2,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = '0,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = '0
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [SEL_W-1:0]  sel
);

    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] mask;

    // Walk downwards so the last assignment is the lowest hit.
    always_comb begin
        hit  = 1'b0;
        sel  = '0;
        base = '0;
        mask = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            base = SLAVE_BASE[i*ADDR_W +: ADDR_W];
            mask = SLAVE_MASK[i*ADDR_W +: ADDR_W];
            if ((addr & mask) == base) begin
                hit = 1'b1;
                sel = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/mem_interconnect.sv
// Single-master, N-slave PicoRV32 bus interconnect with error capture.
// Define MEM_INTERCONNECT_TIMEOUT_EN to enable the per-access timeout.
module mem_interconnect
    import mem_interconnect_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = {
        32'h0300_0000, 32'h0200_0000,
        32'h0010_0000, 32'h0000_0000
    },
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = {
        32'hFF00_0000, 32'hFF00_0000,
        32'hFFF0_0000, 32'hFFF0_0000
    },
    parameter int unsigned TIMEOUT = 255,
    parameter logic [DATA_W-1:0] ERR_DATA =
        DATA_W'(DEFAULT_ERR_DATA)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         m_valid,
    input  logic [ADDR_W-1:0]            m_addr,
    input  logic [DATA_W-1:0]            m_wdata,
    input  logic [DATA_W/8-1:0]          m_wstrb,
    output logic                         m_ready,
    output logic [DATA_W-1:0]            m_rdata,
    output logic [NUM_SLAVES-1:0]        s_valid,
    output logic [ADDR_W-1:0]            s_addr,
    output logic [DATA_W-1:0]            s_wdata,
    output logic [DATA_W/8-1:0]          s_wstrb,
    input  logic [NUM_SLAVES-1:0]        s_ready,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
    output logic                         err_valid,
    output logic                         err_cause,
    output logic [ADDR_W-1:0]            err_addr,
    input  logic                         err_clr
);

    localparam int SEL_W = sel_width(NUM_SLAVES);

    state_t            state_q;
    state_t            state_d;
    logic [SEL_W-1:0]  sel_q;
    logic [SEL_W-1:0]  dec_sel;
    logic              dec_hit;
    logic              sel_ready;
    logic [DATA_W-1:0] sel_rdata;
    logic [DATA_W-1:0] rdata_q;
    logic              miss;
    logic              tmo;
    logic              err_new;
    logic              err_valid_q;
    cause_t            err_cause_q;
    logic [ADDR_W-1:0] err_addr_q;

    mem_addr_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_W     (ADDR_W),
        .SEL_W      (SEL_W),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_decode (
        .addr (m_addr),
        .hit  (dec_hit),
        .sel  (dec_sel)
    );

    assign s_addr  = m_addr;
    assign s_wdata = m_wdata;
    assign s_wstrb = m_wstrb;

    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_ready = s_ready[i];
                sel_rdata = s_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign miss = (state_q == IDLE) && m_valid && !dec_hit;

`ifdef MEM_INTERCONNECT_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state_q == ACTIVE) begin
            cnt_q <= cnt_q + 1'b1;
        end else begin
            cnt_q <= '0;
        end
    end

    // A ready on the threshold cycle still wins.
    assign tmo = (state_q == ACTIVE) && !sel_ready
              && (cnt_q == CNT_W'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign tmo = 1'b0;
`endif

    assign err_new = miss || tmo;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (m_valid) begin
                    state_d = dec_hit ? ACTIVE : RESP;
                end
            end
            ACTIVE: begin
                if (sel_ready || tmo) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_ready = (state_q == RESP);
        s_valid = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            s_valid[i] = (state_q == ACTIVE)
                      && (sel_q == SEL_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q   <= '0;
            rdata_q <= '0;
        end else begin
            if ((state_q == IDLE) && m_valid) begin
                sel_q <= dec_sel;
            end
            if (miss) begin
                rdata_q <= ERR_DATA;
            end else if ((state_q == ACTIVE) && sel_ready) begin
                rdata_q <= sel_rdata;
            end else if (tmo) begin
                rdata_q <= ERR_DATA;
            end
        end
    end

    // The first error is kept until cleared; a clear lets a new one in.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_valid_q <= 1'b0;
            err_cause_q <= CAUSE_DECODE;
            err_addr_q  <= '0;
        end else if (err_new && (!err_valid_q || err_clr)) begin
            err_valid_q <= 1'b1;
            err_cause_q <= tmo ? CAUSE_TIMEOUT : CAUSE_DECODE;
            err_addr_q  <= m_addr;
        end else if (err_clr) begin
            err_valid_q <= 1'b0;
        end
    end

    assign m_rdata   = rdata_q;
    assign err_valid = err_valid_q;
    assign err_cause = err_cause_q;
    assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_mem_interconnect.sv
// Randomised bench for mem_interconnect against a transaction-level model.
// Timeout scenarios run only when MEM_INTERCONNECT_TIMEOUT_EN is defined.
module tb_mem_interconnect;

    localparam int NS  = 4;
    localparam int TMO = 8;
    localparam logic [31:0] ERR = 32'hBADB_AD00;

    // Slave 3 overlaps slaves 0/1, so lowest-index priority is exercised.
    localparam logic [31:0] WB [NS] = '{
        32'h0000_0000, 32'h0010_0000, 32'h2000_0000, 32'h0000_0000
    };
    localparam logic [31:0] WM [NS] = '{
        32'hFFF0_0000, 32'hFFF0_0000, 32'hF000_0000, 32'hFF00_0000
    };
    localparam logic [NS*32-1:0] P_BASE = {WB[3], WB[2], WB[1], WB[0]};
    localparam logic [NS*32-1:0] P_MASK = {WM[3], WM[2], WM[1], WM[0]};

    logic           clk = 1'b0;
    logic           rst;
    logic           m_valid;
    logic [31:0]    m_addr;
    logic [31:0]    m_wdata;
    logic [3:0]     m_wstrb;
    logic           m_ready;
    logic [31:0]    m_rdata;
    logic [NS-1:0]  s_valid;
    logic [31:0]    s_addr;
    logic [31:0]    s_wdata;
    logic [3:0]     s_wstrb;
    logic [NS-1:0]  s_ready;
    logic [NS*32-1:0] s_rdata;
    logic           err_valid;
    logic           err_cause;
    logic [31:0]    err_addr;
    logic           err_clr;

    mem_interconnect #(
        .NUM_SLAVES (NS),
        .ADDR_W     (32),
        .DATA_W     (32),
        .SLAVE_BASE (P_BASE),
        .SLAVE_MASK (P_MASK),
        .TIMEOUT    (TMO),
        .ERR_DATA   (ERR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m_valid   (m_valid),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .m_ready   (m_ready),
        .m_rdata   (m_rdata),
        .s_valid   (s_valid),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_ready   (s_ready),
        .s_rdata   (s_rdata),
        .err_valid (err_valid),
        .err_cause (err_cause),
        .err_addr  (err_addr),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Per-cycle expectations and the sticky error model.
    bit          check_en = 1'b0;
    logic [3:0]  exp_s_valid = '0;
    logic        exp_m_ready = 1'b0;
    logic [31:0] exp_rdata = '0;
    bit          me_valid = 1'b0;
    bit          me_cause = 1'b0;
    logic [31:0] me_addr = '0;
    bit          ev_err = 1'b0;
    bit          ev_cause = 1'b0;
    logic [31:0] ev_addr = '0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < NS; i++) begin
            if ((a & WM[i]) == WB[i]) return i;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        if (check_en) begin
            chk("s_valid", 32'(s_valid), 32'(exp_s_valid));
            chk("m_ready", 32'(m_ready), 32'(exp_m_ready));
            if (exp_m_ready) chk("m_rdata", m_rdata, exp_rdata);
            chk("s_addr", s_addr, m_addr);
            chk("s_wdata", s_wdata, m_wdata);
            chk("s_wstrb", 32'(s_wstrb), 32'(m_wstrb));
            chk("err_valid", 32'(err_valid), 32'(me_valid));
            if (me_valid) begin
                chk("err_cause", 32'(err_cause), 32'(me_cause));
                chk("err_addr", err_addr, me_addr);
            end
        end
    end

    // Advance one cycle; fold in what the finished cycle did to the model.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            me_valid = 1'b0;
            me_cause = 1'b0;
            me_addr  = '0;
        end else if (ev_err && (!me_valid || err_clr)) begin
            me_valid = 1'b1;
            me_cause = ev_cause;
            me_addr  = ev_addr;
        end else if (err_clr) begin
            me_valid = 1'b0;
        end
        ev_err = 1'b0;
        #1;
    endtask

    task automatic noise(input int keep);
        s_rdata = {$urandom, $urandom, $urandom, $urandom};
        s_ready = 4'($urandom);
        if (keep >= 0) s_ready[keep] = 1'b0;
    endtask

    task automatic observe(input int c, inout int rcyc,
                           inout logic [31:0] rdat, inout logic [3:0] sv);
        @(negedge clk);
        sv = sv | s_valid;
        if (m_ready && rcyc < 0) begin
            rcyc = c;
            rdat = m_rdata;
        end
    endtask

    // lat: cycle (from the request) the slave answers; 0 = never.
    task automatic do_txn(input logic [31:0] a, input logic [3:0] ws,
                          input logic [31:0] wd, input int lat,
                          input logic [31:0] tdata, input bit clr0,
                          output int rcyc, output logic [31:0] rdat,
                          output logic [3:0] sv);
        int tgt;
        int c;
        bit done;
        logic [31:0] resp;
        tgt  = decode(a);
        rcyc = -1;
        rdat = '0;
        sv   = '0;
        resp = ERR;
        tick();
        m_valid = 1'b1;
        m_addr  = a;
        m_wdata = wd;
        m_wstrb = ws;
        err_clr = clr0;
        noise(-1);
        exp_s_valid = '0;
        exp_m_ready = 1'b0;
        if (tgt < 0) begin
            ev_err   = 1'b1;
            ev_cause = 1'b0;
            ev_addr  = a;
        end
        observe(0, rcyc, rdat, sv);
        c = 0;
        done = (tgt < 0);
        while (!done && c < 64) begin
            c++;
            tick();
            err_clr = 1'b0;
            exp_s_valid = 4'(1 << tgt);
            noise(tgt);
            if (c == lat) begin
                s_ready[tgt] = 1'b1;
                s_rdata[tgt*32 +: 32] = tdata;
                resp = tdata;
                done = 1'b1;
            end
`ifdef MEM_INTERCONNECT_TIMEOUT_EN
            else if (c == TMO) begin
                ev_err   = 1'b1;
                ev_cause = 1'b1;
                ev_addr  = a;
                done = 1'b1;
            end
`endif
            observe(c, rcyc, rdat, sv);
        end
        if (!done) chk("txn_bound", 32'(c), 32'(lat));
        c++;
        tick();
        err_clr = 1'b0;
        noise(-1);
        exp_s_valid = '0;
        exp_m_ready = 1'b1;
        exp_rdata   = resp;
        observe(c, rcyc, rdat, sv);
        tick();
        m_valid = 1'b0;
        m_addr  = $urandom;
        m_wdata = $urandom;
        m_wstrb = 4'($urandom);
        noise(-1);
        exp_m_ready = 1'b0;
    endtask

    task automatic idle(input int n, input bit rnd_clr);
        for (int i = 0; i < n; i++) begin
            tick();
            m_valid = 1'b0;
            err_clr = rnd_clr ? ($urandom_range(0, 3) == 0) : 1'b1;
            noise(-1);
            exp_s_valid = '0;
            exp_m_ready = 1'b0;
        end
        tick();
        err_clr = 1'b0;
        noise(-1);
    endtask

    int          rc;
    logic [31:0] rd;
    logic [3:0]  sv;
    logic [31:0] a;
    int          lat;
    int          r;

    initial begin
        rst     = 1'b1;
        m_valid = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        m_wstrb = '0;
        err_clr = 1'b0;
        s_ready = '0;
        s_rdata = '0;
        tick();
        check_en = 1'b1;
        @(negedge clk);
        chk("rst_m_ready", 32'(m_ready), 32'd0);
        chk("rst_m_rdata", m_rdata, 32'd0);
        chk("rst_s_valid", 32'(s_valid), 32'd0);
        chk("rst_err_valid", 32'(err_valid), 32'd0);
        chk("rst_err_cause", 32'(err_cause), 32'd0);
        chk("rst_err_addr", err_addr, 32'd0);
        tick();
        rst = 1'b0;

        do_txn(32'h0000_0010, 4'b0000, 32'h0, 3, 32'h1234_5678, 1'b0,
               rc, rd, sv);
        chk("rd_cycle", 32'(rc), 32'd4);
        chk("rd_data", rd, 32'h1234_5678);
        chk("rd_sel", 32'(sv), 32'b0001);

        do_txn(32'h0010_0004, 4'b0011, 32'hCAFE_F00D, 2, 32'h5555_AAAA,
               1'b0, rc, rd, sv);
        chk("wr_cycle", 32'(rc), 32'd3);
        chk("wr_sel", 32'(sv), 32'b0010);

        do_txn(32'h0020_0000, 4'b0000, 32'h0, 1, 32'h0BAD_CAFE, 1'b0,
               rc, rd, sv);
        chk("prio_cycle", 32'(rc), 32'd2);
        chk("prio_sel", 32'(sv), 32'b1000);

        do_txn(32'h8000_0000, 4'b0000, 32'h0, 1, 32'h0, 1'b0, rc, rd, sv);
        chk("miss_cycle", 32'(rc), 32'd1);
        chk("miss_data", rd, 32'hBADB_AD00);
        chk("miss_sel", 32'(sv), 32'b0000);
        chk("miss_err_valid", 32'(err_valid), 32'd1);
        chk("miss_err_cause", 32'(err_cause), 32'd0);
        chk("miss_err_addr", err_addr, 32'h8000_0000);

        do_txn(32'h4000_0000, 4'b0000, 32'h0, 1, 32'h0, 1'b1, rc, rd, sv);
        chk("clr_new_addr", err_addr, 32'h4000_0000);
        do_txn(32'h5000_0000, 4'b0000, 32'h0, 1, 32'h0, 1'b0, rc, rd, sv);
        chk("sticky_addr", err_addr, 32'h4000_0000);

        idle(1, 1'b0);
        @(negedge clk);
        chk("clr_valid", 32'(err_valid), 32'd0);

`ifdef MEM_INTERCONNECT_TIMEOUT_EN
        do_txn(32'h0010_0000, 4'b0000, 32'h0, 0, 32'h0, 1'b0, rc, rd, sv);
        chk("tmo_cycle", 32'(rc), 32'd9);
        chk("tmo_data", rd, 32'hBADB_AD00);
        chk("tmo_err_cause", 32'(err_cause), 32'd1);
        chk("tmo_err_addr", err_addr, 32'h0010_0000);
        do_txn(32'h9000_0000, 4'b0000, 32'h0, 1, 32'h0, 1'b0, rc, rd, sv);
        chk("tmo_keep_addr", err_addr, 32'h0010_0000);
        chk("tmo_keep_cause", 32'(err_cause), 32'd1);
        idle(1, 1'b0);
        @(negedge clk);
        chk("tmo_clr", 32'(err_valid), 32'd0);
        do_txn(32'h2000_0040, 4'b0000, 32'h0, 8, 32'h7777_0001, 1'b0,
               rc, rd, sv);
        chk("thr_cycle", 32'(rc), 32'd9);
        chk("thr_data", rd, 32'h7777_0001);
        chk("thr_err", 32'(err_valid), 32'd0);
`else
        do_txn(32'h2000_0040, 4'b0000, 32'h0, 12, 32'h7777_0001, 1'b0,
               rc, rd, sv);
        chk("slow_cycle", 32'(rc), 32'd13);
        chk("slow_data", rd, 32'h7777_0001);
        chk("slow_err", 32'(err_valid), 32'd0);
`endif

        do_txn(32'h6000_0000, 4'b0000, 32'h0, 1, 32'h0, 1'b0, rc, rd, sv);
        tick();
        m_valid = 1'b1;
        m_addr  = 32'h0000_0100;
        m_wstrb = 4'b0000;
        noise(-1);
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 3) begin
                rst = 1'b1;
                m_valid = 1'b0;
            end
            noise(0);
            exp_s_valid = 4'b0001;
        end
        tick();
        rst = 1'b0;
        noise(-1);
        exp_s_valid = '0;
        @(negedge clk);
        chk("abort_s_valid", 32'(s_valid), 32'd0);
        chk("abort_m_ready", 32'(m_ready), 32'd0);
        chk("abort_err", 32'(err_valid), 32'd0);
        do_txn(32'h0000_0200, 4'b0000, 32'h0, 2, 32'h0F0F_1234, 1'b0,
               rc, rd, sv);
        chk("fresh_cycle", 32'(rc), 32'd3);
        chk("fresh_data", rd, 32'h0F0F_1234);

        for (int n = 0; n < 160; n++) begin
            r = $urandom_range(0, 6);
            case (r)
                0: a = {12'h000, 20'($urandom)};
                1: a = {12'h001, 20'($urandom)};
                2: a = {4'h2, 28'($urandom)};
                3: a = {8'h00, 4'($urandom_range(2, 15)), 20'($urandom)};
                4: a = {4'($urandom_range(8, 15)), 28'($urandom)};
                default: a = $urandom;
            endcase
            lat = $urandom_range(1, 12);
`ifdef MEM_INTERCONNECT_TIMEOUT_EN
            if ($urandom_range(0, 5) == 0) lat = 0;
`endif
            do_txn(a, 4'($urandom), $urandom, lat, $urandom,
                   ($urandom_range(0, 7) == 0), rc, rd, sv);
            if (decode(a) >= 0 && lat > 0 && lat < TMO) begin
                chk("rnd_cycle", 32'(rc), 32'(lat + 1));
            end
            if (decode(a) < 0) chk("rnd_miss_cycle", 32'(rc), 32'd1);
            idle($urandom_range(0, 3), 1'b1);
        end

        tick();
        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
